// File: rtl/fios_pkg.sv
// fios_pkg: shared definitions for the FIOS result path.
//   BLK_W   - width of one radix-2^17 block
//   state_t - result reducer FSM states
//   pe_nb() - number of processing elements for a given block count s,
//             shared with the memory block
package fios_pkg;

  localparam int BLK_W = 17;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PUSH    = 2'd2,
    DONE    = 2'd3
  } state_t;

  function automatic int pe_nb(input int s);
    return (2 * s + 5) / 9 + 1;
  endfunction

endpackage

// File: rtl/serial_sub_cell.sv
// serial_sub_cell: combinational one-block subtractor with borrow chain.
// Present only when FIOS_FINAL_SUB_EN is defined (final subtraction build).
// Ports:
//   a          in  BLK_W  minuend block
//   b          in  BLK_W  subtrahend block
//   borrow_in  in  1      borrow from the previous (less significant) block
//   diff       out BLK_W  a - b - borrow_in, low BLK_W bits
//   borrow_out out 1      borrow into the next block
`ifdef FIOS_FINAL_SUB_EN
module serial_sub_cell
  import fios_pkg::*;
(
  input  logic [BLK_W-1:0] a,
  input  logic [BLK_W-1:0] b,
  input  logic             borrow_in,
  output logic [BLK_W-1:0] diff,
  output logic             borrow_out
);

  // The 18-bit difference wraps on underflow, so its MSB is the borrow out.
  assign {borrow_out, diff} = {1'b0, a} - {1'b0, b} - {{BLK_W{1'b0}}, borrow_in};

endmodule
`endif

// File: rtl/fios_result_reducer.sv
// fios_result_reducer: collects the s result blocks of the last PE
// (LSB-first), optionally applies the final conditional subtraction
// T >= n ? T - n : T block-serially, then pushes the s result blocks to
// memory LSB-first, one per cycle.
// Build option: FIOS_FINAL_SUB_EN - when defined, the subtractor and diff
// register are built; otherwise the raw T is pushed (lazy reduction) and
// n_blk_i / res_carry_i are unused.
// Ports:
//   clock_i      in  1   clock, rising edge
//   reset_i      in  1   asynchronous active-low reset
//   start_i      in  1   arms collection of a new result
//   res_blk_i    in  17  result block from the last PE
//   n_blk_i      in  17  modulus block with the same index
//   res_valid_i  in  1   res_blk_i / n_blk_i valid
//   res_carry_i  in  1   top carry of T, sampled with the s-th block
//   res_o        out 17  block to memory res_i (0 when not pushing)
//   res_push_o   out 1   push strobe to memory res_push_i
//   busy_o       out 1   high from start until done
//   done_o       out 1   one-cycle pulse after the last push
//
// state   | meaning
// IDLE    | waiting for start_i, res_valid_i ignored
// COLLECT | shifting in s valid blocks, gaps allowed
// PUSH    | s consecutive pushes of the selected result
// DONE    | raises done_o on the next edge, back to IDLE
module fios_result_reducer
  import fios_pkg::*;
#(
  parameter int s = 16
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [BLK_W-1:0] res_blk_i,
  input  logic [BLK_W-1:0] n_blk_i,
  input  logic             res_valid_i,
  input  logic             res_carry_i,
  output logic [BLK_W-1:0] res_o,
  output logic             res_push_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int CW = (s > 1) ? $clog2(s) : 1;
  localparam int RW = BLK_W * s;
  localparam logic [CW-1:0] LAST = CW'(s - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [RW-1:0]    raw_q, raw_d;
  logic [BLK_W-1:0] res_q, res_d;
  logic             res_push_q, res_push_d;
  logic             done_q, done_d;
  logic [BLK_W-1:0] push_blk;

`ifdef FIOS_FINAL_SUB_EN
  logic [RW-1:0]    diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             carry_q, carry_d;
  logic [BLK_W-1:0] sub_diff;
  logic             sub_borrow;
  logic             sel_diff;

  serial_sub_cell u_sub (
    .a          (res_blk_i),
    .b          (n_blk_i),
    .borrow_in  (borrow_q),
    .diff       (sub_diff),
    .borrow_out (sub_borrow)
  );

  // carry and borrow are frozen once PUSH is entered, so the selection is
  // stable for the whole push burst. T == n leaves no borrow -> zero result.
  assign sel_diff = carry_q | ~borrow_q;
  assign push_blk = sel_diff ? diff_q[BLK_W-1:0] : raw_q[BLK_W-1:0];
`else
  logic unused_inputs;
  assign unused_inputs = ^{n_blk_i, res_carry_i};
  assign push_blk      = raw_q[BLK_W-1:0];
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    raw_d      = raw_q;
    res_d      = '0;
    res_push_d = 1'b0;
    done_d     = 1'b0;
`ifdef FIOS_FINAL_SUB_EN
    diff_d     = diff_q;
    borrow_d   = borrow_q;
    carry_d    = carry_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = COLLECT;
          cnt_d    = '0;
`ifdef FIOS_FINAL_SUB_EN
          borrow_d = 1'b0;
          carry_d  = 1'b0;
`endif
        end
      end
      COLLECT: begin
        if (res_valid_i) begin
          raw_d    = {res_blk_i, raw_q[RW-1:BLK_W]};
`ifdef FIOS_FINAL_SUB_EN
          diff_d   = {sub_diff, diff_q[RW-1:BLK_W]};
          borrow_d = sub_borrow;
`endif
          if (cnt_q == LAST) begin
`ifdef FIOS_FINAL_SUB_EN
            carry_d = res_carry_i;
`endif
            state_d = PUSH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      PUSH: begin
        res_push_d = 1'b1;
        res_d      = push_blk;
        raw_d      = {{BLK_W{1'b0}}, raw_q[RW-1:BLK_W]};
`ifdef FIOS_FINAL_SUB_EN
        diff_d     = {{BLK_W{1'b0}}, diff_q[RW-1:BLK_W]};
`endif
        if (cnt_q == LAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      raw_q      <= '0;
      res_q      <= '0;
      res_push_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      raw_q      <= raw_d;
      res_q      <= res_d;
      res_push_q <= res_push_d;
      done_q     <= done_d;
    end
  end

`ifdef FIOS_FINAL_SUB_EN
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      diff_q   <= '0;
      borrow_q <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      carry_q  <= carry_d;
    end
  end
`endif

  assign res_o      = res_q;
  assign res_push_o = res_push_q;
  assign done_o     = done_q;
  assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_fios_result_reducer.sv
`timescale 1ns/1ps
module tb_fios_result_reducer;
  localparam int S  = 4;
  localparam int BW = 17;
  localparam int RW = BW * S;

  logic          clock_i = 1'b0;
  logic          reset_i = 1'b0;
  logic          start_i = 1'b0;
  logic [BW-1:0] res_blk_i = '0;
  logic [BW-1:0] n_blk_i = '0;
  logic          res_valid_i = 1'b0;
  logic          res_carry_i = 1'b0;
  logic [BW-1:0] res_o;
  logic          res_push_o;
  logic          busy_o;
  logic          done_o;

  fios_result_reducer #(.s(S)) dut (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .start_i     (start_i),
    .res_blk_i   (res_blk_i),
    .n_blk_i     (n_blk_i),
    .res_valid_i (res_valid_i),
    .res_carry_i (res_carry_i),
    .res_o       (res_o),
    .res_push_o  (res_push_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clock_i = ~clock_i;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [BW-1:0] exp_q[$];
  logic [63:0]   base_q[$];   // edge time of the s-th valid for each op
  bit            mon_en = 1'b1;
  int            push_idx = 0;
  int            done_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: samples 1 ns after each rising edge.
  always @(posedge clock_i) begin
    #1;
    if (mon_en && reset_i) begin
      if (res_push_o) begin
        if (exp_q.size() == 0 || base_q.size() == 0) begin
          check("unexpected_push", 64'(res_push_o), 64'd0);
        end else begin
          check("push_data", 64'(res_o), 64'(exp_q.pop_front()));
          check("push_time", $time - 1, base_q[0] + 64'(10 * (push_idx + 1)));
          push_idx++;
        end
      end else begin
        check("res_o_idle", 64'(res_o), 64'd0);
      end
      if (done_o) begin
        if (base_q.size() == 0) begin
          check("unexpected_done", 64'(done_o), 64'd0);
        end else begin
          check("done_time", $time - 1, base_q.pop_front() + 64'(10 * (S + 1)));
          check("pushes_before_done", 64'(push_idx), 64'(S));
        end
        push_idx = 0;
        done_cnt++;
      end
    end
  end

  // Reference: whole-number view of T and n. Entered and left at a falling edge.
  task automatic run_op(input logic [RW-1:0] t, input logic [RW-1:0] n,
                        input logic c, input int gmin, input int gmax);
    logic [RW:0] tt, nn, r;
    int prev;
    int gap;
    tt = {c, t};
    nn = {1'b0, n};
`ifdef FIOS_FINAL_SUB_EN
    r = (tt >= nn) ? tt - nn : tt;
`else
    r = tt;
`endif
    for (int k = 0; k < S; k++) exp_q.push_back(r[BW*k +: BW]);
    start_i = 1'b1;
    @(negedge clock_i);
    start_i = 1'b0;
    check("busy_after_start", 64'(busy_o), 64'd1);
    for (int k = 0; k < S; k++) begin
      gap = (gmin == gmax) ? gmin : int'($urandom_range(gmax, gmin));
      repeat (gap) begin
        res_valid_i = 1'b0;
        res_blk_i   = BW'($urandom);
        n_blk_i     = BW'($urandom);
        res_carry_i = 1'($urandom);
        @(negedge clock_i);
      end
      res_valid_i = 1'b1;
      res_blk_i   = t[BW*k +: BW];
      n_blk_i     = n[BW*k +: BW];
      res_carry_i = (k == S - 1) ? c : 1'($urandom);
      if (k == S - 1) base_q.push_back($time + 5);
      @(negedge clock_i);
    end
    res_valid_i = 1'b0;
    res_carry_i = 1'b0;
    prev = done_cnt;
    for (int i = 0; i < 40 && done_cnt == prev; i++) @(negedge clock_i);
    check("done_seen", 64'(done_cnt != prev), 64'd1);
    if (done_cnt == prev) begin
      exp_q.delete();
      base_q.delete();
      push_idx = 0;
    end
    check("busy_after_done", 64'(busy_o), 64'd0);
  endtask

  logic [RW-1:0] t_v, n_v;
  bit            seen;

  initial begin
    reset_i = 1'b0;
    repeat (3) @(negedge clock_i);
    check("rst_res_o", 64'(res_o), 64'd0);
    check("rst_push", 64'(res_push_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    reset_i = 1'b1;
    @(negedge clock_i);

    // Valids while idle must be ignored.
    repeat (3) begin
      res_valid_i = 1'b1;
      res_blk_i   = BW'($urandom);
      @(negedge clock_i);
    end
    res_valid_i = 1'b0;
    check("idle_ignores_valid", 64'(busy_o), 64'd0);

    run_op(RW'(7), RW'(5), 1'b0, 0, 0);
    run_op(RW'(3), RW'(5), 1'b0, 0, 0);
    run_op(RW'(2), RW'(5), 1'b1, 0, 0);
    for (int k = 0; k < S; k++) t_v[BW*k +: BW] = 17'h0ABCD;
    run_op(t_v, t_v, 1'b0, 0, 0);
    run_op(t_v, t_v, 1'b0, 3, 3);

    // Abort mid-push: no done_o, outputs drop at once.
    mon_en  = 1'b0;
    start_i = 1'b1;
    @(negedge clock_i);
    start_i = 1'b0;
    for (int k = 0; k < S; k++) begin
      res_valid_i = 1'b1;
      res_blk_i   = BW'(k + 1);
      n_blk_i     = '0;
      @(negedge clock_i);
    end
    res_valid_i = 1'b0;
    @(posedge clock_i);
    @(posedge clock_i);
    #2;
    check("push_before_abort", 64'(res_push_o), 64'd1);
    reset_i = 1'b0;
    #1;
    check("abort_push", 64'(res_push_o), 64'd0);
    check("abort_busy", 64'(busy_o), 64'd0);
    check("abort_res_o", 64'(res_o), 64'd0);
    seen = 1'b0;
    repeat (2) begin
      @(negedge clock_i);
      seen = seen | done_o;
    end
    reset_i = 1'b1;
    repeat (8) begin
      @(negedge clock_i);
      seen = seen | done_o;
    end
    check("no_done_after_abort", 64'(seen), 64'd0);
    mon_en = 1'b1;

    run_op(RW'(7), RW'(5), 1'b0, 0, 0);

    for (int i = 0; i < 24; i++) begin
      for (int k = 0; k < S; k++) begin
        t_v[BW*k +: BW] = BW'($urandom);
        n_v[BW*k +: BW] = BW'($urandom);
      end
      if (i % 6 == 0) n_v = t_v;
      run_op(t_v, n_v, 1'($urandom), 0, 2);
    end

    repeat (5) @(negedge clock_i);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
